// File: rtl/systolic_feeder.sv
// systolic_feeder: input-side driver for the FP-INT systolic MAC array.
// Buffers up to K_MAX load beats (one activation per row, one integer weight
// per column), then streams them: each activation is held for P cycles while
// the matching weight leaves bit-serially, LSB first. Row i and column j are
// skewed by i and j register stages respectively.
module systolic_feeder #(
    parameter int ACT_WIDTH = 16,
    parameter int N         = 2,
    parameter int W_MAX     = 8,
    parameter int K_MAX     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [3:0]             precision_i,
    input  logic [4:0]             k_len_i,
    input  logic                   ld_valid_i,
    output logic                   ld_ready_o,
    input  logic [N*ACT_WIDTH-1:0] ld_act_i,
    input  logic [N*W_MAX-1:0]     ld_w_i,
    output logic                   active_o,
    output logic [N*ACT_WIDTH-1:0] act_in_o,
    output logic [N-1:0]           w_in_o,
    output logic [3:0]             precision_out_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int KW = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam int BW = (W_MAX > 1) ? $clog2(W_MAX) : 1;
    localparam int DW = (N > 2) ? $clog2(N - 1) : 1;
    localparam logic [3:0]    WMAX_P     = 4'(W_MAX);
    localparam logic [4:0]    KMAX_L     = 5'(K_MAX);
    localparam logic [DW-1:0] DRAIN_LAST = DW'((N > 1) ? N - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    kc_q, kc_d;        // load beat counter
    logic [4:0]    k_q, k_d;          // stream beat counter
    logic [3:0]    b_q, b_d;          // stream bit counter
    logic [DW-1:0] dcnt_q, dcnt_d;    // drain cycle counter
    logic [3:0]    p_q, p_d;          // latched effective precision
    logic [4:0]    klen_q, klen_d;    // latched job length

    logic ld_ready_q, active_q, busy_q, done_q;

    logic [N*ACT_WIDTH-1:0] act_mem [K_MAX];
    logic [N*W_MAX-1:0]     w_mem   [K_MAX];

    logic                   ld_fire;
    logic                   start_ok;
    logic [3:0]             p_eff;
    logic                   stream_next;
    logic [N*ACT_WIDTH-1:0] rd_act;
    logic [N*W_MAX-1:0]     rd_w;
    logic [N*ACT_WIDTH-1:0] pre_act_d;
    logic [N-1:0]           pre_w_d;

    assign ld_fire  = ld_valid_i & ld_ready_q;
    assign start_ok = start_i && (k_len_i != 5'd0) && (k_len_i <= KMAX_L);
    assign p_eff    = ((precision_i >= 4'd1) && (precision_i <= WMAX_P)) ? precision_i : WMAX_P;

    // Next-state and counter logic for the job sequencer
    always_comb begin
        state_d = state_q;
        kc_d    = kc_q;
        k_d     = k_q;
        b_d     = b_q;
        dcnt_d  = dcnt_q;
        p_d     = p_q;
        klen_d  = klen_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    p_d     = p_eff;
                    klen_d  = k_len_i;
                    kc_d    = 5'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (ld_fire) begin
                    kc_d = kc_q + 5'd1;
                    if (kc_q == klen_q - 5'd1) begin
                        state_d = S_STREAM;
                        k_d     = 5'd0;
                        b_d     = 4'd0;
                    end
                end
            end
            S_STREAM: begin
                if (b_q == p_q - 4'd1) begin
                    b_d = 4'd0;
                    if (k_q == klen_q - 5'd1) begin
                        state_d = (N == 1) ? S_DONE : S_DRAIN;
                        dcnt_d  = '0;
                    end else begin
                        k_d = k_q + 5'd1;
                    end
                end else begin
                    b_d = b_q + 4'd1;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state, counters and decoded control outputs, all registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            kc_q       <= '0;
            k_q        <= '0;
            b_q        <= '0;
            dcnt_q     <= '0;
            p_q        <= '0;
            klen_q     <= '0;
            ld_ready_q <= 1'b0;
            active_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            kc_q       <= kc_d;
            k_q        <= k_d;
            b_q        <= b_d;
            dcnt_q     <= dcnt_d;
            p_q        <= p_d;
            klen_q     <= klen_d;
            ld_ready_q <= (state_d == S_LOAD);
            active_q   <= (state_d == S_STREAM);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
        end
    end

    // Beat buffer write; contents need no reset since every job reloads them
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            act_mem[kc_q[KW-1:0]] <= ld_act_i;
            w_mem[kc_q[KW-1:0]]   <= ld_w_i;
        end
    end

    // Buffer read for the beat streamed next cycle; a single-beat job reads
    // the beat being written this same cycle, so forward it from the port
    always_comb begin
        rd_act = act_mem[k_d[KW-1:0]];
        rd_w   = w_mem[k_d[KW-1:0]];
        if (ld_fire && (kc_q == k_d)) begin
            rd_act = ld_act_i;
            rd_w   = ld_w_i;
        end
    end

    assign stream_next = (state_d == S_STREAM);
    assign pre_act_d   = stream_next ? rd_act : '0;

    genvar gi;

    // Row skew: row gi passes through gi+1 registers, the first of which is
    // the output register shared with row 0 timing
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            logic [ACT_WIDTH-1:0] pipe_q [gi+1];

            // Shift the row activation down its skew chain
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int m = 0; m <= gi; m++) pipe_q[m] <= '0;
                end else begin
                    pipe_q[0] <= pre_act_d[gi*ACT_WIDTH +: ACT_WIDTH];
                    for (int m = 1; m <= gi; m++) pipe_q[m] <= pipe_q[m-1];
                end
            end

            assign act_in_o[gi*ACT_WIDTH +: ACT_WIDTH] = pipe_q[gi];
        end
    endgenerate

    // Column skew: the selected weight bit runs down a gi+1 stage chain
    generate
        for (gi = 0; gi < N; gi++) begin : g_col
            logic [W_MAX-1:0] col_word;
            logic             wpipe_q [gi+1];

            assign col_word     = rd_w[gi*W_MAX +: W_MAX];
            assign pre_w_d[gi]  = stream_next & col_word[b_d[BW-1:0]];

            // Shift the column weight bit down its skew chain
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int m = 0; m <= gi; m++) wpipe_q[m] <= 1'b0;
                end else begin
                    wpipe_q[0] <= pre_w_d[gi];
                    for (int m = 1; m <= gi; m++) wpipe_q[m] <= wpipe_q[m-1];
                end
            end

            assign w_in_o[gi] = wpipe_q[gi];
        end
    endgenerate

    assign ld_ready_o      = ld_ready_q;
    assign active_o        = active_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign precision_out_o = p_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed testbench for systolic_feeder (N=2, ACT_WIDTH=16, W_MAX=8, K_MAX=16).
module tb_systolic_feeder;

    localparam int AW = 16;
    localparam int N  = 2;
    localparam int WM = 8;
    localparam int KM = 16;
    localparam int VW = 3 + N*AW + N;

    logic            clk;
    logic            rst;
    logic            start_i;
    logic [3:0]      precision_i;
    logic [4:0]      k_len_i;
    logic            ld_valid_i;
    logic            ld_ready_o;
    logic [N*AW-1:0] ld_act_i;
    logic [N*WM-1:0] ld_w_i;
    logic            active_o;
    logic [N*AW-1:0] act_in_o;
    logic [N-1:0]    w_in_o;
    logic [3:0]      precision_out_o;
    logic            busy_o;
    logic            done_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] job_act [KM][N];
    logic [WM-1:0] job_w   [KM][N];
    int            job_p;
    int            job_klen;
    logic [VW-1:0] obs;
    logic [VW-1:0] expv;

    systolic_feeder #(.ACT_WIDTH(AW), .N(N), .W_MAX(WM), .K_MAX(KM)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .precision_i     (precision_i),
        .k_len_i         (k_len_i),
        .ld_valid_i      (ld_valid_i),
        .ld_ready_o      (ld_ready_o),
        .ld_act_i        (ld_act_i),
        .ld_w_i          (ld_w_i),
        .active_o        (active_o),
        .act_in_o        (act_in_o),
        .w_in_o          (w_in_o),
        .precision_out_o (precision_out_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    // Fill the job tables with a distinct pattern per seed
    function automatic void fill_job(input int seed, input int klen, input int p);
        for (int k = 0; k < KM; k++) begin
            for (int i = 0; i < N; i++) begin
                job_act[k][i] = 16'(seed*4099 + k*257 + i*61 + 1);
                job_w[k][i]   = 8'(seed*53 + k*29 + i*101 + 7);
            end
        end
        job_klen = klen;
        job_p    = p;
    endfunction

    // Reference response at cycle s+r for the current job tables
    function automatic logic [VW-1:0] exp_vec(input int r);
        int              len;
        int              q;
        logic            a, bz, d;
        logic [N*AW-1:0] acts;
        logic [N-1:0]    ws;
        len  = job_klen * job_p;
        a    = (r >= 0) && (r < len);
        bz   = (r >= 0) && (r <= len + N - 1);
        d    = (r == len + N - 1);
        acts = '0;
        ws   = '0;
        for (int i = 0; i < N; i++) begin
            q = r - i;
            if (q >= 0 && q < len) acts[i*AW +: AW] = job_act[q / job_p][i];
        end
        for (int j = 0; j < N; j++) begin
            q = r - j;
            if (q >= 0 && q < len) ws[j] = job_w[q / job_p][j][q % job_p];
        end
        return {a, bz, d, acts, ws};
    endfunction

    // Pulse start for one cycle, then scramble the sampled-on-start inputs
    task automatic kick(input logic [3:0] p, input logic [4:0] kl);
        start_i     = 1'b1;
        precision_i = p;
        k_len_i     = kl;
        tick;
        start_i     = 1'b0;
        precision_i = 4'd7;
        k_len_i     = 5'd9;
    endtask

    // Drive job beats; with stall set ld_valid follows 1,0,0,1 repeating
    task automatic load_beats(input int klen, input bit stall);
        int   idx = 0;
        int   cyc = 0;
        logic v;
        while (idx < klen && cyc < 200) begin
            v = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            ld_valid_i = v;
            if (v) begin
                for (int i = 0; i < N; i++) begin
                    ld_act_i[i*AW +: AW] = job_act[idx][i];
                    ld_w_i[i*WM +: WM]   = job_w[idx][i];
                end
            end else begin
                ld_act_i = '1;
                ld_w_i   = '1;
            end
            if (v && ld_ready_o) idx++;
            tick;
            cyc++;
        end
        ld_valid_i = 1'b0;
        ld_act_i   = '0;
        ld_w_i     = '0;
        n_checks++;
        if (idx < klen) begin
            n_fail++;
            $display("FAIL load_timeout accepted=%0d required=%0d", idx, klen);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick;
        tick;
        n_checks++;
        if ({ld_ready_o, active_o, busy_o, done_o, precision_out_o, act_in_o, w_in_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h required=0",
                     {ld_ready_o, active_o, busy_o, done_o, precision_out_o, act_in_o, w_in_o});
        end
        rst = 1'b1;
        ld_valid_i = 1'b1;
        tick;
        tick;
        ld_valid_i = 1'b0;
        n_checks++;
        if ({ld_ready_o, active_o, busy_o, done_o, precision_out_o, act_in_o, w_in_o} !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset got=%h required=0",
                     {ld_ready_o, active_o, busy_o, done_o, precision_out_o, act_in_o, w_in_o});
        end
        $display("test_reset done");
    endtask

    task automatic test_basic;
        logic [7:0]  w0_tab;
        logic [7:0]  w1_tab;
        logic        e_act, e_busy, e_done, e_w0, e_w1;
        logic [15:0] e_r0, e_r1;
        w0_tab = 8'b0011_1011;   // 1,1,0,1,1,1,0,0 on s..s+7
        w1_tab = 8'b1100_0101;   // 1,0,1,0,0,0,1,1 on s+1..s+8
        job_act[0][0] = 16'h3C00; job_act[0][1] = 16'hBC00;
        job_act[1][0] = 16'h4000; job_act[1][1] = 16'h0000;
        job_w[0][0] = 8'hAB; job_w[1][0] = 8'h73;
        job_w[0][1] = 8'hF5; job_w[1][1] = 8'h2C;
        job_klen = 2;
        job_p    = 4;
        kick(4'd4, 5'd2);
        n_checks++;
        if ({ld_ready_o, busy_o, active_o, precision_out_o} !== {1'b1, 1'b1, 1'b0, 4'd4}) begin
            n_fail++;
            $display("FAIL basic_load_entry got=%b required=%b",
                     {ld_ready_o, busy_o, active_o, precision_out_o}, {1'b1, 1'b1, 1'b0, 4'd4});
        end
        load_beats(2, 1'b0);
        for (int r = 0; r <= 10; r++) begin
            e_act  = (r < 8);
            e_busy = (r <= 9);
            e_done = (r == 9);
            e_r0   = (r < 4) ? 16'h3C00 : ((r < 8) ? 16'h4000 : 16'h0000);
            e_r1   = (r >= 1 && r <= 4) ? 16'hBC00 : 16'h0000;
            e_w0   = (r < 8) ? w0_tab[r] : 1'b0;
            e_w1   = (r >= 1 && r <= 8) ? w1_tab[r-1] : 1'b0;
            expv   = {e_act, e_busy, e_done, e_r1, e_r0, e_w1, e_w0};
            obs    = {active_o, busy_o, done_o, act_in_o, w_in_o};
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL basic r=%0d got=%h required=%h", r, obs, expv);
            end
            tick;
        end
        $display("test_basic done");
    endtask

    task automatic test_clamp;
        fill_job(1, 2, 8);
        kick(4'd0, 5'd2);
        n_checks++;
        if (precision_out_o !== 4'd8) begin
            n_fail++;
            $display("FAIL clamp0_prec got=%0d required=8", precision_out_o);
        end
        load_beats(2, 1'b0);
        for (int r = 0; r <= job_klen*job_p + N; r++) begin
            obs  = {active_o, busy_o, done_o, act_in_o, w_in_o};
            expv = exp_vec(r);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL clamp0 r=%0d got=%h required=%h", r, obs, expv);
            end
            tick;
        end
        fill_job(2, 1, 8);
        kick(4'd12, 5'd1);
        n_checks++;
        if (precision_out_o !== 4'd8) begin
            n_fail++;
            $display("FAIL clamp12_prec got=%0d required=8", precision_out_o);
        end
        load_beats(1, 1'b0);
        for (int r = 0; r <= job_klen*job_p + N; r++) begin
            obs  = {active_o, busy_o, done_o, act_in_o, w_in_o};
            expv = exp_vec(r);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL clamp12 r=%0d got=%h required=%h", r, obs, expv);
            end
            tick;
        end
        $display("test_clamp done");
    endtask

    task automatic test_klen;
        kick(4'd3, 5'd0);
        tick;
        n_checks++;
        if ({busy_o, ld_ready_o, precision_out_o} !== {1'b0, 1'b0, 4'd8}) begin
            n_fail++;
            $display("FAIL klen0_ignored got=%b required=%b", {busy_o, ld_ready_o, precision_out_o},
                     {1'b0, 1'b0, 4'd8});
        end
        kick(4'd3, 5'd17);
        tick;
        n_checks++;
        if ({busy_o, ld_ready_o, precision_out_o} !== {1'b0, 1'b0, 4'd8}) begin
            n_fail++;
            $display("FAIL klen17_ignored got=%b required=%b", {busy_o, ld_ready_o, precision_out_o},
                     {1'b0, 1'b0, 4'd8});
        end
        fill_job(3, 16, 1);
        kick(4'd1, 5'd16);
        load_beats(16, 1'b0);
        for (int r = 0; r <= job_klen*job_p + N; r++) begin
            obs  = {active_o, busy_o, done_o, act_in_o, w_in_o};
            expv = exp_vec(r);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL klen16 r=%0d got=%h required=%h", r, obs, expv);
            end
            tick;
        end
        $display("test_klen done");
    endtask

    task automatic test_stall;
        fill_job(4, 3, 2);
        kick(4'd2, 5'd3);
        load_beats(3, 1'b1);
        for (int r = 0; r <= job_klen*job_p + N; r++) begin
            obs  = {active_o, busy_o, done_o, act_in_o, w_in_o};
            expv = exp_vec(r);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL stall r=%0d got=%h required=%h", r, obs, expv);
            end
            tick;
        end
        $display("test_stall done");
    endtask

    task automatic test_start_busy;
        int dones = 0;
        fill_job(5, 2, 3);
        kick(4'd3, 5'd2);
        load_beats(2, 1'b0);
        for (int r = 0; r <= job_klen*job_p + N; r++) begin
            obs  = {active_o, busy_o, done_o, act_in_o, w_in_o};
            expv = exp_vec(r);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL start_busy r=%0d got=%h required=%h", r, obs, expv);
            end
            if (done_o === 1'b1) dones++;
            if (r == 2) begin
                start_i     = 1'b1;
                precision_i = 4'd5;
                k_len_i     = 5'd1;
            end else begin
                start_i = 1'b0;
            end
            tick;
        end
        for (int c = 0; c < 3; c++) begin
            if (done_o === 1'b1) dones++;
            tick;
        end
        n_checks++;
        if ({dones[3:0], precision_out_o, busy_o} !== {4'd1, 4'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL start_busy_after dones=%0d prec=%0d busy=%b required 1,3,0",
                     dones, precision_out_o, busy_o);
        end
        $display("test_start_busy done");
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        fill_job(6, 3, 2);
        kick(4'd2, 5'd3);
        load_beats(3, 1'b0);
        for (int r = 0; r <= 2; r++) begin
            obs  = {active_o, busy_o, done_o, act_in_o, w_in_o};
            expv = exp_vec(r);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL reset_mid_pre r=%0d got=%h required=%h", r, obs, expv);
            end
            if (r < 2) tick;
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({ld_ready_o, active_o, busy_o, done_o, precision_out_o, act_in_o, w_in_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_clear got=%h required=0",
                     {ld_ready_o, active_o, busy_o, done_o, precision_out_o, act_in_o, w_in_o});
        end
        tick;
        rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (done_o === 1'b1 || busy_o === 1'b1) dones++;
            tick;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL reset_mid_nodone got=%0d busy/done cycles required=0", dones);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back;
        fill_job(7, 2, 3);
        kick(4'd3, 5'd2);
        load_beats(2, 1'b0);
        for (int r = 0; r <= job_klen*job_p + N; r++) begin
            obs  = {active_o, busy_o, done_o, act_in_o, w_in_o};
            expv = exp_vec(r);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL b2b_first r=%0d got=%h required=%h", r, obs, expv);
            end
            if (r == job_klen*job_p + N) begin
                start_i     = 1'b1;
                precision_i = 4'd5;
                k_len_i     = 5'd2;
            end
            tick;
        end
        start_i     = 1'b0;
        precision_i = 4'd7;
        k_len_i     = 5'd9;
        n_checks++;
        if ({ld_ready_o, busy_o, precision_out_o} !== {1'b1, 1'b1, 4'd5}) begin
            n_fail++;
            $display("FAIL b2b_accept got=%b required=%b", {ld_ready_o, busy_o, precision_out_o},
                     {1'b1, 1'b1, 4'd5});
        end
        fill_job(8, 2, 5);
        load_beats(2, 1'b0);
        for (int r = 0; r <= job_klen*job_p + N; r++) begin
            obs  = {active_o, busy_o, done_o, act_in_o, w_in_o};
            expv = exp_vec(r);
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL b2b_second r=%0d got=%h required=%h", r, obs, expv);
            end
            tick;
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        rst         = 1'b0;
        start_i     = 1'b0;
        precision_i = 4'd0;
        k_len_i     = 5'd0;
        ld_valid_i  = 1'b0;
        ld_act_i    = '0;
        ld_w_i      = '0;
        job_p       = 1;
        job_klen    = 1;
        test_reset;
        test_basic;
        test_clamp;
        test_klen;
        test_stall;
        test_start_busy;
        test_reset_mid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Input-side driver for the FP-INT systolic MAC array. It accepts one activation per row and one integer weight per column per load beat over a valid/ready handshake, and buffers up to K_MAX beats. It then streams them into the array: each activation is held for `precision` cycles while the matching weight is shifted out bit-serially, LSB first. Row and column inputs are skewed by their index, `active` is generated, and `done` pulses once the last skewed bit has left the block.

## Interface
- ACT_WIDTH, 16, activation (FP) width per row
- N, 2, array dimension (rows = columns = N)
- W_MAX, 8, maximum weight bit width; also the per-column storage width
- K_MAX, 16, buffer depth, i.e. the maximum dot-product length

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse that begins a job
- precision  in  4  weight bits per weight, sampled on start
- k_len  in  5  beats per job, sampled on start
- ld_valid  in  1  load beat valid
- ld_ready  out  1  feeder accepts a beat
- ld_act  in  N*ACT_WIDTH  row i activation at [i*ACT_WIDTH +: ACT_WIDTH]
- ld_w  in  N*W_MAX  column j weight at [j*W_MAX +: W_MAX]; the low P bits are used
- active  out  1  array valid, aligned with row 0 / column 0
- act_in  out  N*ACT_WIDTH  skewed row activations
- w_in  out  N  skewed column weight bits
- precision_out  out  4  latched effective precision P
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse

## Operation
- Effective precision P: equals `precision` when 1 ≤ precision ≤ W_MAX; otherwise P = W_MAX.
- A start with k_len = 0, or with k_len > K_MAX, is ignored.
- A start while busy is ignored.
- FSM states: IDLE → LOAD → STREAM → DRAIN → DONE → IDLE.
- IDLE
  - All outputs are 0.
  - A valid start latches P and k_len, resets the beat counter, and moves to LOAD.
- LOAD
  - ld_ready = 1.
  - Each cycle with ld_valid & ld_ready writes beat index kc into the buffer and increments kc.
  - When beat k_len−1 is accepted, go to STREAM. ld_ready drops in that same transition.
- STREAM
  - Runs for L = k_len*P cycles.
  - Counters: beat k (0..k_len−1) and bit b (0..P−1). b wraps to 0 and k increments after b = P−1.
  - Pre-skew row i value = act[k][i]. Pre-skew column j bit = w[k][j][b].
  - active = 1 throughout.
  - After the last cycle, go to DRAIN, or straight to DONE when N = 1.
- DRAIN
  - Lasts N−1 cycles with active = 0.
  - Pre-skew values are 0; the skew pipes keep flushing.
- DONE
  - done = 1 for exactly one cycle, then IDLE.
- Skew
  - act_in row i is the pre-skew row value delayed by i registers.
  - w_in column j is the pre-skew column bit delayed by j registers.
  - Row 0 and column 0 have no added delay.
  - Pre-skew values are 0 outside STREAM.
- busy = 1 in LOAD, STREAM, DRAIN and DONE.
- precision_out holds P from the start cycle until the next accepted start.
- ld_valid outside LOAD is ignored and has no side effects.

## Timing
- All outputs are registered. Reset value of every output is 0.
- On reset, both counters and all skew registers clear and the FSM enters IDLE.
- Reset mid-job aborts the job: no done pulse, and buffer contents are don't-care.
- Start accepted at cycle 0:
  - LOAD and ld_ready = 1 from cycle 1.
  - Zero-wait loading makes the last beat accepted at cycle k_len.
- Last beat accepted at cycle t:
  - STREAM begins at s = t+1 with active = 1.
  - active = 1 on cycles s .. s+L−1.
- Row i activation for beat k is presented on cycles s+k*P+i .. s+k*P+i+P−1.
- Column j bit b of beat k is presented at cycle s+k*P+b+j.
- DRAIN covers cycles s+L .. s+L+N−2.
- done = 1 at cycle s+L+N−1. busy falls and IDLE is reached at s+L+N.
- A new start is accepted at s+L+N at the earliest.
- Stalls: ld_valid low during LOAD stalls loading. Data is never dropped, and the same beat index is not rewritten.

## Test plan
- Basic job (N=2, precision 4, k_len 2). Weights col0 = {0xB, 0x3}, col1 = {0x5, 0xC}. Acts row0 = {0x3C00, 0x4000}, row1 = {0xBC00, 0x0000}. Required response:
  - active high s..s+7.
  - w_in[0] = 1,1,0,1,1,1,0,0 on s..s+7.
  - w_in[1] = 1,0,1,0,0,0,1,1 on s+1..s+8.
  - row0 = 0x3C00 on s..s+3, then 0x4000 on s+4..s+7.
  - row1 = 0xBC00 on s+1..s+4, then 0 on s+5..s+8.
  - done at s+9.
- Precision clamp: precision = 0 and precision = 12 → precision_out = 8, and each beat streams for 8 cycles.
- k_len boundaries:
  - k_len = 0 → start ignored, busy stays 0.
  - k_len = 16 at precision 1 → active high for exactly 16 cycles, and all 16 beats appear in order.
- Load stalls: ld_valid toggling 1,0,0,1 → exactly k_len beats are captured, in order, and STREAM starts one cycle after the last accepted beat.
- Start while busy: a start pulse during STREAM → ignored, precision_out unchanged, exactly one done pulse.
- Reset mid-STREAM: rst low for one cycle → all outputs 0 immediately, no done pulse, and a fresh job afterwards runs correctly.
